// File: rtl/rr_port_arb_pkg.sv
// Shared definitions for the round-robin port arbiter: FSM encoding,
// default hold limit and a helper for sizing the hold counter.
package rr_port_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    localparam int HOLD_MAX_DEF = 2048;

    // One spare bit above what HOLD_MAX needs, so the counter can never wrap
    function automatic int hold_cnt_width(input int hold_max);
        return $clog2(hold_max) + 1;
    endfunction

endpackage

// File: rtl/rr_port_arb_if.sv
// Request/grant bundle between the requesting ports (master) and the
// arbiter (slave).
interface rr_port_arb_if #(
    parameter int ARB_WIDTH    = 4,
    parameter int ARB_WIDTH_L2 = $clog2(ARB_WIDTH)
);
    logic [ARB_WIDTH-1:0]    req;
    logic [ARB_WIDTH-1:0]    rel;
    logic [ARB_WIDTH-1:0]    gnt_vec;
    logic [ARB_WIDTH_L2-1:0] gnt_bin;
    logic                    gnt_vld;
    logic                    err_timeout;

    modport master (
        output req, rel,
        input  gnt_vec, gnt_bin, gnt_vld, err_timeout
    );

    modport slave (
        input  req, rel,
        output gnt_vec, gnt_bin, gnt_vld, err_timeout
    );
endinterface

// File: rtl/rr_port_arb_prio_enc.sv
// Lowest-index-wins priority encoder: one-hot and binary form of the
// lowest set bit, plus a flag saying any bit was set.
module prio_enc
    import rr_port_arb_pkg::*;
#(
    parameter int PE_W    = 4,
    parameter int PE_W_L2 = $clog2(PE_W)
) (
    input  logic [PE_W-1:0]    pe_in,
    output logic [PE_W-1:0]    pe_vec_out,
    output logic [PE_W_L2-1:0] pe_bin_out,
    output logic               pe_found
);

    // Scan high to low so the last hit (lowest index) overrides
    always_comb begin
        pe_vec_out = '0;
        pe_bin_out = '0;
        pe_found   = 1'b0;
        for (int i = PE_W - 1; i >= 0; i--) begin
            if (pe_in[i]) begin
                pe_vec_out    = '0;
                pe_vec_out[i] = 1'b1;
                pe_bin_out    = PE_W_L2'(i);
                pe_found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_port_arb.sv
// Round-robin port arbiter. A grant is held until the owner releases it,
// drops its request, or the hold limit forces it off (flagged on
// err_timeout). Every release costs one idle cycle before the next grant.
module rr_port_arb
    import rr_port_arb_pkg::*;
#(
    parameter int ARB_WIDTH    = 4,
    parameter int ARB_WIDTH_L2 = $clog2(ARB_WIDTH),
    parameter int HOLD_MAX     = HOLD_MAX_DEF
) (
    input  logic          clk,
    input  logic          rstn,
    rr_port_arb_if.slave  arb
);

    localparam int CNT_W = hold_cnt_width(HOLD_MAX);

    arb_state_e              state_q, state_d;
    logic [ARB_WIDTH-1:0]    gnt_vec_q, gnt_vec_d;
    logic [ARB_WIDTH_L2-1:0] gnt_bin_q, gnt_bin_d;
    logic                    gnt_vld_q, gnt_vld_d;
    logic                    err_q, err_d;
    logic [ARB_WIDTH_L2-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic [ARB_WIDTH-1:0]    mask;
    logic [ARB_WIDTH-1:0]    req_m;
    logic [ARB_WIDTH-1:0]    m_vec, r_vec, win_vec;
    logic [ARB_WIDTH_L2-1:0] m_bin, r_bin, win_bin;
    logic                    m_found, r_found;
    logic                    rel_hit, req_hit, at_limit;

    // Ports strictly above the last winner get first pick
    always_comb begin
        mask = '0;
        for (int i = 0; i < ARB_WIDTH; i++)
            mask[i] = (i > int'(ptr_q));
    end

    assign req_m = arb.req & mask;

    prio_enc #(.PE_W(ARB_WIDTH), .PE_W_L2(ARB_WIDTH_L2)) u_pe_msk (
        .pe_in      (req_m),
        .pe_vec_out (m_vec),
        .pe_bin_out (m_bin),
        .pe_found   (m_found)
    );

    prio_enc #(.PE_W(ARB_WIDTH), .PE_W_L2(ARB_WIDTH_L2)) u_pe_raw (
        .pe_in      (arb.req),
        .pe_vec_out (r_vec),
        .pe_bin_out (r_bin),
        .pe_found   (r_found)
    );

    // Fall back to the unmasked encoder when nobody above the pointer asks
    assign win_vec = m_found ? m_vec : r_vec;
    assign win_bin = m_found ? m_bin : r_bin;

    // Only the current owner's rel/req bits matter while holding
    assign rel_hit  = |(gnt_vec_q & arb.rel);
    assign req_hit  = |(gnt_vec_q & arb.req);
    assign at_limit = (cnt_q == CNT_W'(HOLD_MAX - 1));

    // State and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            gnt_vec_q <= '0;
            gnt_bin_q <= '0;
            gnt_vld_q <= 1'b0;
            err_q     <= 1'b0;
            ptr_q     <= ARB_WIDTH_L2'(ARB_WIDTH - 1);
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_vec_q <= gnt_vec_d;
            gnt_bin_q <= gnt_bin_d;
            gnt_vld_q <= gnt_vld_d;
            err_q     <= err_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state, next-grant and hold-counter logic
    always_comb begin
        state_d   = state_q;
        gnt_vec_d = gnt_vec_q;
        gnt_bin_d = gnt_bin_q;
        gnt_vld_d = gnt_vld_q;
        err_d     = 1'b0;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                gnt_vec_d = '0;
                gnt_bin_d = '0;
                gnt_vld_d = 1'b0;
                if (r_found) begin
                    state_d   = HOLD;
                    gnt_vec_d = win_vec;
                    gnt_bin_d = win_bin;
                    gnt_vld_d = 1'b1;
                    ptr_d     = win_bin;
                    cnt_d     = '0;
                end
            end
            HOLD: begin
                // A real release (or abort) beats the timeout in the same cycle
                if (rel_hit || !req_hit || at_limit) begin
                    state_d   = IDLE;
                    gnt_vec_d = '0;
                    gnt_bin_d = '0;
                    gnt_vld_d = 1'b0;
                    err_d     = !(rel_hit || !req_hit);
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                gnt_vec_d = '0;
                gnt_bin_d = '0;
                gnt_vld_d = 1'b0;
            end
        endcase
    end

    assign arb.gnt_vec     = gnt_vec_q;
    assign arb.gnt_bin     = gnt_bin_q;
    assign arb.gnt_vld     = gnt_vld_q;
    assign arb.err_timeout = err_q;

endmodule

// File: tb/tb_rr_port_arb.sv
// Directed bench for rr_port_arb (4 ports, hold limit 16 cycles).
module tb_rr_port_arb;

    logic clk;
    logic rstn;
    int   checks;
    int   errors;

    rr_port_arb_if #(.ARB_WIDTH(4)) arb_if ();

    rr_port_arb #(.ARB_WIDTH(4), .ARB_WIDTH_L2(2), .HOLD_MAX(16)) dut (
        .clk  (clk),
        .rstn (rstn),
        .arb  (arb_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_gnt(input string tag, input logic [3:0] vec, input logic [1:0] bin,
                           input logic vld, input logic err);
        chk({tag, ".vec"}, 32'(arb_if.gnt_vec), 32'(vec));
        chk({tag, ".bin"}, 32'(arb_if.gnt_bin), 32'(bin));
        chk({tag, ".vld"}, 32'(arb_if.gnt_vld), 32'(vld));
        chk({tag, ".err"}, 32'(arb_if.err_timeout), 32'(err));
    endtask

    initial begin
        logic [3:0] exp_vec;
        checks = 0;
        errors = 0;
        rstn = 1'b0;
        arb_if.req = '0;
        arb_if.rel = '0;

        // Reset state
        tick();
        tick();
        chk_gnt("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        rstn = 1'b1;
        tick();
        chk_gnt("idle_noreq", 4'b0000, 2'd0, 1'b0, 1'b0);

        // All four request: order 0,1,2,3,0 with one idle cycle between grants
        arb_if.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_vec = 4'b0001 << (k % 4);
            tick();
            chk_gnt($sformatf("rr_grant%0d", k), exp_vec, 2'(k % 4), 1'b1, 1'b0);
            tick();
            tick();
            chk_gnt($sformatf("rr_hold%0d", k), exp_vec, 2'(k % 4), 1'b1, 1'b0);
            arb_if.rel = exp_vec;
            tick();
            arb_if.rel = '0;
            if (k == 4) arb_if.req = '0;
            chk_gnt($sformatf("rr_bubble%0d", k), 4'b0000, 2'd0, 1'b0, 1'b0);
        end
        tick();
        chk_gnt("idle_after_rr", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Single requester port 2, then 0 and 2 request: wraps to port 0
        arb_if.req = 4'b0100;
        tick();
        chk_gnt("p2_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
        tick(); tick(); tick(); tick();
        arb_if.rel = 4'b0100;
        tick();
        arb_if.rel = '0;
        arb_if.req = 4'b0101;
        chk_gnt("p2_release", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        chk_gnt("wrap_to_p0", 4'b0001, 2'd0, 1'b1, 1'b0);
        arb_if.rel = 4'b0001;
        tick();
        arb_if.rel = '0;
        arb_if.req = '0;
        chk_gnt("p0_release", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Port 1: foreign rel bits ignored, own rel releases
        arb_if.req = 4'b0010;
        tick();
        chk_gnt("p1_grant", 4'b0010, 2'd1, 1'b1, 1'b0);
        arb_if.rel = 4'b1101;
        tick();
        arb_if.rel = '0;
        chk_gnt("p1_foreign_rel", 4'b0010, 2'd1, 1'b1, 1'b0);
        arb_if.rel = 4'b0010;
        tick();
        arb_if.rel = '0;
        arb_if.req = '0;
        chk_gnt("p1_release", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Port 3 with no release: forced off after 16 hold cycles
        arb_if.req = 4'b1000;
        tick();
        chk_gnt("p3_grant", 4'b1000, 2'd3, 1'b1, 1'b0);
        for (int c = 1; c < 16; c++) begin
            tick();
            chk_gnt($sformatf("p3_hold%0d", c), 4'b1000, 2'd3, 1'b1, 1'b0);
        end
        tick();
        arb_if.req = '0;
        chk_gnt("p3_timeout", 4'b0000, 2'd0, 1'b0, 1'b1);
        tick();
        chk_gnt("p3_timeout_pulse_end", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Port 3 again, release on the very last hold cycle: no timeout
        arb_if.req = 4'b1000;
        tick();
        chk_gnt("p3b_grant", 4'b1000, 2'd3, 1'b1, 1'b0);
        for (int c = 1; c < 16; c++) tick();
        chk_gnt("p3b_last_hold", 4'b1000, 2'd3, 1'b1, 1'b0);
        arb_if.rel = 4'b1000;
        tick();
        arb_if.rel = '0;
        arb_if.req = '0;
        chk_gnt("p3b_rel_at_limit", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        chk_gnt("p3b_no_err", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Port 2 aborts by dropping its request
        arb_if.req = 4'b0100;
        tick();
        chk_gnt("p2_abort_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
        tick();
        arb_if.req = '0;
        tick();
        chk_gnt("p2_abort", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Async reset mid-hold of port 3, then port 0 wins first
        arb_if.req = 4'b1000;
        tick();
        chk_gnt("p3_pre_reset", 4'b1000, 2'd3, 1'b1, 1'b0);
        tick();
        #2;
        rstn = 1'b0;
        #1;
        chk_gnt("async_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        arb_if.req = 4'b1001;
        tick();
        chk_gnt("in_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        rstn = 1'b1;
        tick();
        chk_gnt("post_reset_p0", 4'b0001, 2'd0, 1'b1, 1'b0);
        arb_if.rel = 4'b0001;
        tick();
        arb_if.rel = '0;
        arb_if.req = '0;
        chk_gnt("post_reset_release", 4'b0000, 2'd0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
